// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the systolic DSP array: scalar float word, PE error flags,
// and the state encoding of the PE-sharing arbiter.
package dsp_sys_arr_pkg;

  typedef logic [31:0] single_float;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } error;

  typedef enum logic {
    ARB   = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/pe_tag_fifo.sv
// Synchronous tag FIFO; pointers carry one extra wrap bit so full and empty
// are told apart by the MSB alone.
module pe_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_wdata,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_rdata,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count   = r_wptr - r_rptr;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];
  assign w_pop_ok  = i_pop && !o_empty;
  // a pop in the same cycle frees the slot, so push is allowed even when full
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/pe_share_arb.sv
// Round-robin sharing of one multiply PE among NREQ requesters; results are
// routed back in issue order through a tag FIFO.
//   state | meaning
//   ARB   | pick next requester, capture its operand pair
//   ISSUE | present the pair on PE A/B until both ports handshake
module pe_share_arb
  import dsp_sys_arr_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NREQ-1:0]           s_req_tvalid,
  output logic [NREQ-1:0]           s_req_tready,
  input  single_float [NREQ-1:0]    s_req_a_tdata,
  input  single_float [NREQ-1:0]    s_req_b_tdata,
  output logic                      m_pe_a_tvalid,
  input  logic                      m_pe_a_tready,
  output single_float               m_pe_a_tdata,
  output logic                      m_pe_b_tvalid,
  input  logic                      m_pe_b_tready,
  output single_float               m_pe_b_tdata,
  input  logic                      s_pe_res_tvalid,
  output logic                      s_pe_res_tready,
  input  single_float               s_pe_res_tdata,
  input  error                      s_pe_res_tuser,
  output logic [NREQ-1:0]           m_rsp_tvalid,
  input  logic [NREQ-1:0]           m_rsp_tready,
  output single_float               m_rsp_tdata,
  output error                      m_rsp_tuser,
  output logic [$clog2(MAX_OUT):0]  outstanding,
  output logic                      orphan_err
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int OW  = $clog2(MAX_OUT) + 1;

  logic            r_rst_n;
  logic            w_rst_n;
  arb_state_t      r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_id;
  single_float     r_a;
  single_float     r_b;
  logic            r_a_vld;
  logic            r_b_vld;
  logic            r_orphan;

  logic            w_grant_vld;
  logic [IDW-1:0]  w_grant_id;
  logic [IDW-1:0]  w_cand;
  logic            w_a_done;
  logic            w_b_done;
  logic            w_issue_done;
  logic            w_pop;
  logic [IDW-1:0]  w_head;
  logic            w_full;
  logic            w_empty;
  logic [OW-1:0]   w_count;

  // assertion is immediate, release lands on an aclk edge
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rst_n <= 1'b0;
    else          r_rst_n <= 1'b1;
  end
  assign w_rst_n = r_rst_n;

  // lowest offset from r_rr_ptr wins, so scan from the far end down
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (s_req_tvalid[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_cand;
      end
    end
    if (!w_rst_n || (r_state != ARB) || w_full) w_grant_vld = 1'b0;
  end

  assign s_req_tready = w_grant_vld ? (NREQ'(1) << w_grant_id) : '0;

  assign w_a_done     = !r_a_vld || m_pe_a_tready;
  assign w_b_done     = !r_b_vld || m_pe_b_tready;
  assign w_issue_done = (r_state == ISSUE) && w_a_done && w_b_done;

  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= ARB;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_a_vld  <= 1'b0;
      r_b_vld  <= 1'b0;
      r_orphan <= 1'b0;
    end else begin
      if (s_pe_res_tvalid && w_empty) r_orphan <= 1'b1;
      case (r_state)
        ARB: begin
          if (w_grant_vld) begin
            r_id     <= w_grant_id;
            r_a      <= s_req_a_tdata[w_grant_id];
            r_b      <= s_req_b_tdata[w_grant_id];
            r_a_vld  <= 1'b1;
            r_b_vld  <= 1'b1;
            r_rr_ptr <= (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_pe_a_tready) r_a_vld <= 1'b0;
          if (m_pe_b_tready) r_b_vld <= 1'b0;
          if (w_issue_done)  r_state <= ARB;
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign m_pe_a_tvalid = r_a_vld;
  assign m_pe_b_tvalid = r_b_vld;
  assign m_pe_a_tdata  = r_a;
  assign m_pe_b_tdata  = r_b;

  pe_tag_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .aclk    (aclk),
    .aresetn (w_rst_n),
    .i_push  (w_issue_done),
    .i_wdata (r_id),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // with nothing in flight the result is swallowed and flagged as orphan
  assign s_pe_res_tready = w_rst_n && (w_empty || m_rsp_tready[w_head]);
  assign w_pop           = s_pe_res_tvalid && s_pe_res_tready && !w_empty;
  assign m_rsp_tvalid    = (s_pe_res_tvalid && !w_empty) ? (NREQ'(1) << w_head) : '0;
  assign m_rsp_tdata     = w_rst_n ? s_pe_res_tdata : '0;
  assign m_rsp_tuser     = w_rst_n ? s_pe_res_tuser : '0;
  assign outstanding     = w_count;
  assign orphan_err      = r_orphan;

endmodule
